// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
//   Shared types for the sound path (sequencer and tone oscillator):
//   the global sound mode, the melody selector, the note record, and the
//   melody ROM lookups.
// -----------------------------------------------------------------------------
package sound_pkg;

  // Global sound mode; OFF mutes the whole sound path.
  typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;

  // The encoding order is the priority order: a larger value wins.
  typedef enum logic [1:0] {
    MEL_NONE  = 2'd0,
    MEL_EAT   = 2'd1,
    MEL_START = 2'd2,
    MEL_DIE   = 2'd3
  } melody_t;

  // One note: half-period count (0 = rest) and duration in steps.
  typedef struct packed {
    logic [7:0] freq;
    logic [3:0] len;
  } note_t;

  // Melody ROM. Indices past the end of a melody return an all-zero note.
  function automatic note_t note_rom(input melody_t mel, input logic [1:0] idx);
    note_t n;
    n = '{freq: 8'd0, len: 4'd0};
    case (mel)
      MEL_EAT: begin
        case (idx)
          2'd0:    n = '{freq: 8'd60, len: 4'd2};
          2'd1:    n = '{freq: 8'd40, len: 4'd2};
          default: n = '{freq: 8'd0,  len: 4'd0};
        endcase
      end
      MEL_START: begin
        case (idx)
          2'd0:    n = '{freq: 8'd120, len: 4'd3};
          2'd1:    n = '{freq: 8'd90,  len: 4'd3};
          2'd2:    n = '{freq: 8'd60,  len: 4'd6};
          default: n = '{freq: 8'd0,   len: 4'd0};
        endcase
      end
      MEL_DIE: begin
        case (idx)
          2'd0:    n = '{freq: 8'd80,  len: 4'd4};
          2'd1:    n = '{freq: 8'd0,   len: 4'd2};
          2'd2:    n = '{freq: 8'd120, len: 4'd4};
          default: n = '{freq: 8'd200, len: 4'd10};
        endcase
      end
      default: n = '{freq: 8'd0, len: 4'd0};
    endcase
    return n;
  endfunction

  // Number of notes in a melody (0 for MEL_NONE).
  function automatic logic [2:0] melody_len(input melody_t mel);
    logic [2:0] len;
    case (mel)
      MEL_EAT:   len = 3'd2;
      MEL_START: len = 3'd3;
      MEL_DIE:   len = 3'd4;
      default:   len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
//   Prescaler that divides the clock into duration steps. A free-running
//   counter wraps at STEP_CYCLES-1; step is high for the one cycle in which
//   the counter sits at its last value, i.e. once every STEP_CYCLES cycles.
//   clear forces the counter back to 0 so a new melody starts a fresh step.
// Ports
//   clk    in  system clock
//   nRst   in  asynchronous active-low reset
//   clear  in  restart the prescaler from 0 on the next edge
//   step   out 1-cycle pulse at the end of each step
// -----------------------------------------------------------------------------
module step_timer #(
  parameter int unsigned STEP_CYCLES = 12000
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic step
);

  localparam int unsigned W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign step = (cnt_q == LAST);

endmodule

// File: rtl/sound_sequencer.sv
// -----------------------------------------------------------------------------
// sound_sequencer
//   Turns single-cycle game events into short melodies for the tone
//   oscillator. Events and the sound mode are registered first; the sequencer
//   FSM acts on the registered copies, so an event sampled at edge N produces
//   its first note at edge N+1. Each note holds its outputs for
//   len*STEP_CYCLES cycles; the next note loads on the edge the previous one
//   ends. A higher-or-equal priority event preempts the current melody.
// Ports
//   clk        in  system clock
//   nRst       in  asynchronous active-low reset
//   state      in  sound mode; OFF mutes, aborts and blocks new melodies
//   evt_eat    in  1-cycle pulse: play EAT melody
//   evt_start  in  1-cycle pulse: play START melody
//   evt_die    in  1-cycle pulse: play DIE melody
//   freq       out note half-period count; 0 when idle
//   playSound  out high while a non-rest note is sounding
//   busy       out high while any melody (including rests) is in progress
// -----------------------------------------------------------------------------
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       nRst,
  input  MODE_TYPES  state,
  input  logic       evt_eat,
  input  logic       evt_start,
  input  logic       evt_die,
  output logic [7:0] freq,
  output logic       playSound,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} seq_state_t;

  seq_state_t st_q;
  melody_t    mel_q;
  melody_t    req_q, req_d;
  logic       on_q;
  logic [1:0] idx_q;
  logic [3:0] step_cnt_q;
  logic [3:0] len_q;
  logic [7:0] freq_q;
  logic       play_q;
  logic       busy_q;

  logic       load;
  logic       note_end;
  logic       last_note;
  logic       clear;
  logic       step;
  note_t      first_note;
  note_t      next_note;

  // Zero-length notes are played as one step.
  function automatic logic [3:0] eff_len(input note_t n);
    return (n.len == 4'd0) ? 4'd1 : n.len;
  endfunction

  always_comb begin
    // Priority encoder: DIE > START > EAT; lower simultaneous events are dropped.
    req_d = MEL_NONE;
    if (evt_die)        req_d = MEL_DIE;
    else if (evt_start) req_d = MEL_START;
    else if (evt_eat)   req_d = MEL_EAT;

    // mel_q is MEL_NONE while idle, so any real request passes the compare.
    load       = on_q && (req_q != MEL_NONE) && (req_q >= mel_q);
    note_end   = (st_q == PLAY) && step && (step_cnt_q == len_q - 4'd1);
    last_note  = ({1'b0, idx_q} == melody_len(mel_q) - 3'd1);
    first_note = note_rom(req_q, 2'd0);
    next_note  = note_rom(mel_q, idx_q + 2'd1);
    // Hold the prescaler at 0 whenever no note is timing, and restart it on load.
    clear      = load || !on_q || (st_q == IDLE);
  end

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .nRst  (nRst),
    .clear (clear),
    .step  (step)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      on_q       <= 1'b0;
      req_q      <= MEL_NONE;
      st_q       <= IDLE;
      mel_q      <= MEL_NONE;
      idx_q      <= 2'd0;
      step_cnt_q <= 4'd0;
      len_q      <= 4'd0;
      freq_q     <= 8'd0;
      play_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      on_q  <= (state == ON);
      req_q <= req_d;

      if (!on_q) begin
        // Mode OFF aborts any melody; the event registered alongside is ignored.
        st_q       <= IDLE;
        mel_q      <= MEL_NONE;
        idx_q      <= 2'd0;
        step_cnt_q <= 4'd0;
        len_q      <= 4'd0;
        freq_q     <= 8'd0;
        play_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else if (load) begin
        // Takes precedence over note_end so an event on the final edge wins.
        st_q       <= PLAY;
        mel_q      <= req_q;
        idx_q      <= 2'd0;
        step_cnt_q <= 4'd0;
        len_q      <= eff_len(first_note);
        freq_q     <= first_note.freq;
        play_q     <= (first_note.freq != 8'd0);
        busy_q     <= 1'b1;
      end else if (note_end) begin
        if (last_note) begin
          st_q       <= IDLE;
          mel_q      <= MEL_NONE;
          idx_q      <= 2'd0;
          step_cnt_q <= 4'd0;
          len_q      <= 4'd0;
          freq_q     <= 8'd0;
          play_q     <= 1'b0;
          busy_q     <= 1'b0;
        end else begin
          idx_q      <= idx_q + 2'd1;
          step_cnt_q <= 4'd0;
          len_q      <= eff_len(next_note);
          freq_q     <= next_note.freq;
          play_q     <= (next_note.freq != 8'd0);
        end
      end else if ((st_q == PLAY) && step) begin
        step_cnt_q <= step_cnt_q + 4'd1;
      end
    end
  end

  assign freq      = freq_q;
  assign playSound = play_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sound_sequencer
//   Scoreboard bench for sound_sequencer with STEP_CYCLES=4. Each accepted
//   event pushes the per-cycle expected outputs of its melody into a queue;
//   every cycle the observed outputs are popped against it (idle when empty).
// -----------------------------------------------------------------------------
module tb_sound_sequencer;
  import sound_pkg::*;

  localparam int unsigned STEP = 4;

  typedef struct packed {
    logic [7:0] freq;
    logic       ps;
    logic       busy;
  } obs_t;

  localparam obs_t IDLE_OBS = '0;

  logic       clk = 1'b0;
  logic       nRst;
  MODE_TYPES  state;
  logic       evt_eat, evt_start, evt_die;
  logic [7:0] freq;
  logic       playSound, busy;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  sound_sequencer #(
    .STEP_CYCLES (STEP)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .state     (state),
    .evt_eat   (evt_eat),
    .evt_start (evt_start),
    .evt_die   (evt_die),
    .freq      (freq),
    .playSound (playSound),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got freq=%0d pS=%0b busy=%0b, want freq=%0d pS=%0b busy=%0b",
               tag, $time, got.freq, got.ps, got.busy, exp.freq, exp.ps, exp.busy);
    end
  endtask

  // Advance n cycles, comparing outputs at each falling edge.
  task automatic run(input int n, input string tag);
    obs_t e;
    repeat (n) begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = IDLE_OBS;
      check(tag, {freq, playSound, busy}, e);
    end
  endtask

  task automatic add_note(input logic [7:0] f, input int l);
    repeat (l * STEP) exp_q.push_back({f, (f != 8'd0), 1'b1});
  endtask

  task automatic push_melody(input melody_t m);
    case (m)
      MEL_EAT:   begin add_note(60, 2); add_note(40, 2); end
      MEL_START: begin add_note(120, 3); add_note(90, 3); add_note(60, 6); end
      MEL_DIE:   begin add_note(80, 4); add_note(0, 2); add_note(120, 4); add_note(200, 10); end
      default:   ;
    endcase
  endtask

  // The cycle right after the sampling edge still shows the old behaviour;
  // everything after it is replaced.
  task automatic keep_front();
    obs_t f;
    if (exp_q.size() > 0) f = exp_q[0];
    else                  f = IDLE_OBS;
    exp_q.delete();
    exp_q.push_back(f);
  endtask

  // Pulse events {die,start,eat} for one cycle; 'accepted' is the melody that
  // should result, or MEL_NONE if the events must be ignored.
  task automatic fire(input logic [2:0] evts, input melody_t accepted, input string tag);
    {evt_die, evt_start, evt_eat} = evts;
    if (accepted != MEL_NONE) begin
      keep_front();
      push_melody(accepted);
    end
    run(1, tag);
    {evt_die, evt_start, evt_eat} = 3'b000;
  endtask

  initial begin
    nRst  = 1'b0;
    state = ON;
    {evt_die, evt_start, evt_eat} = 3'b000;
    #1 check("reset", {freq, playSound, busy}, IDLE_OBS);
    @(negedge clk);
    nRst = 1'b1;
    run(3, "idle");

    // EAT alone
    fire(3'b001, MEL_EAT, "eat");
    run(20, "eat");

    // DIE alone, including its rest
    fire(3'b100, MEL_DIE, "die");
    run(85, "die");

    // EAT during DIE is lower priority and ignored
    fire(3'b100, MEL_DIE, "die2");
    run(10, "die2");
    fire(3'b001, MEL_NONE, "eat_in_die");
    run(80, "die2_tail");

    // DIE during EAT note 1 preempts from note 0
    fire(3'b001, MEL_EAT, "eat3");
    run(12, "eat3");
    fire(3'b100, MEL_DIE, "die_preempt");
    run(85, "die_preempt");

    // All three at once: DIE wins
    fire(3'b111, MEL_DIE, "all3");
    run(85, "all3");

    // START restarts itself
    fire(3'b010, MEL_START, "start");
    run(20, "start");
    fire(3'b010, MEL_START, "start_restart");
    run(55, "start_restart");

    // Event on the edge the last note ends: new melody wins, busy stays 1
    fire(3'b001, MEL_EAT, "eat_end");
    run(15, "eat_end");
    fire(3'b001, MEL_EAT, "eat_chain");
    run(20, "eat_chain");

    // Mode OFF mid-START aborts; DIE while OFF is ignored
    fire(3'b010, MEL_START, "start_off");
    run(10, "start_off");
    state = OFF;
    keep_front();
    run(3, "off");
    fire(3'b100, MEL_NONE, "die_off");
    run(8, "off_idle");
    state = ON;
    run(3, "on_again");

    // Async reset mid-melody, then normal operation
    fire(3'b001, MEL_EAT, "eat_rst");
    run(5, "eat_rst");
    #2 nRst = 1'b0;
    #1 check("async_rst", {freq, playSound, busy}, IDLE_OBS);
    exp_q.delete();
    @(negedge clk);
    nRst = 1'b1;
    run(3, "post_rst");
    fire(3'b001, MEL_EAT, "eat_after_rst");
    run(20, "eat_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
